// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects,
// RV32M funct3 codes and the iterative mul/div FSM state type.
package exec_pkg;

    // ALUControl encodings; ALU_SR shifts arithmetically when InstrE[30] is set
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SR  = 3'b111;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RD  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    // RV32M funct3 codes
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mdState_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit. Operands are reduced to magnitudes
// on start, processed for XLEN steps (shift-add or restoring divide) and the
// sign is reapplied when the result is read in DONE.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    mdState_t          state, stateNext;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   hi, lo, opnd, aRaw;
    logic [2:0]        opR;
    logic              negRes, negRem, divZero;
    logic              signedA, signedB, sa, sb;
    logic [XLEN-1:0]   magA, magB;
    logic [XLEN:0]     mulSum, remShift, diff;
    logic [2*XLEN-1:0] prod;

    // Operand signedness and magnitudes for the op being started
    always_comb begin
        signedA = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        signedB = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        sa      = signedA & a[XLEN-1];
        sb      = signedB & b[XLEN-1];
        magA    = sa ? -a : a;
        magB    = sb ? -b : b;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        remShift = {hi, lo[XLEN-1]};
        diff     = remShift - {1'b0, opnd};
    end

    // FSM state register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // FSM next state: start stalls immediately, RUN lasts XLEN cycles
    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(XLEN - 1)) stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Step counter, cleared whenever the unit is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (state == RUN)  cnt <= cnt + CW'(1);
        else                    cnt <= '0;
    end

    // Operand latch on start and shift-register update during RUN
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opR     <= op;
            aRaw    <= a;
            divZero <= (b == '0);
            negRes  <= sa ^ sb;
            negRem  <= sa;
            hi      <= '0;
            lo      <= op[2] ? magA : magB;
            opnd    <= op[2] ? magB : magA;
        end else if (state == RUN) begin
            if (opR[2]) begin
                hi <= diff[XLEN] ? remShift[XLEN-1:0] : diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~diff[XLEN]};
            end else begin
                hi <= mulSum[XLEN:1];
                lo <= {mulSum[0], lo[XLEN-1:1]};
            end
        end
    end

    // Result selection with sign restoration and divide special cases
    always_comb begin
        prod = negRes ? -{hi, lo} : {hi, lo};
        case (opR)
            MD_MUL:                      result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result = divZero ? '1 : (negRes ? -lo : lo);
            default:                     result = divZero ? aRaw : (negRem ? -hi : hi);
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage with forwarding, ALU, branch/jump resolution, RV32M unit and
// the EX/MEM pipeline register. Defining EXEC_FAST_MUL_EN makes the four
// multiplies single-cycle combinational; divides always stay iterative.
module execute_stage_md
    import exec_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RDW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [31:0]     InstrE,
    input  logic [RDW-1:0]  RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            ALUSrcE,
    input  logic            MulDivE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            Predict_branchE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            MispredictE,
    output logic            StallE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [31:0]     InstrM,
    output logic [RDW-1:0]  RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0]        srcA, srcB, aluB, aluResult, exResult, target, jalrSum;
    logic signed [XLEN-1:0] srcAS, aluBS;
    logic [SHW-1:0]         shamt;
    logic [2:0]             funct3;
    logic                   zero, neg, cond, pcSrcRaw;
    logic                   mdStart, mdBusy, mdDone, fastMul;
    logic [XLEN-1:0]        mdResult, fastResult;

    assign funct3 = InstrE[14:12];

    // Forwarding muxes for both source operands
    always_comb begin
        case (ForwardAE)
            FWD_RD:  srcA = RD1_E;
            FWD_WB:  srcA = ResultW;
            FWD_MEM: srcA = ALUResultM;
            default: srcA = '0;
        endcase
        case (ForwardBE)
            FWD_RD:  srcB = RD2_E;
            FWD_WB:  srcB = ResultW;
            FWD_MEM: srcB = ALUResultM;
            default: srcB = '0;
        endcase
    end

    // Single-cycle ALU
    always_comb begin
        aluB  = ALUSrcE ? ImmExtE : srcB;
        srcAS = srcA;
        aluBS = aluB;
        shamt = aluB[SHW-1:0];
        case (ALUControlE)
            ALU_ADD: aluResult = srcA + aluB;
            ALU_SUB: aluResult = srcA - aluB;
            ALU_AND: aluResult = srcA & aluB;
            ALU_OR:  aluResult = srcA | aluB;
            ALU_XOR: aluResult = srcA ^ aluB;
            ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, (srcAS < aluBS)};
            ALU_SLL: aluResult = srcA << shamt;
            default: begin
                if (InstrE[30]) aluResult = srcAS >>> shamt;
                else            aluResult = srcA >> shamt;
            end
        endcase
    end

    // Branch condition from the ALU flags and redirect target
    always_comb begin
        zero = (aluResult == '0);
        neg  = aluResult[XLEN-1];
        case (funct3)
            3'b000:         cond = zero;
            3'b001:         cond = ~zero;
            3'b100, 3'b110: cond = neg;
            3'b101, 3'b111: cond = ~neg;
            default:        cond = 1'b0;
        endcase
        pcSrcRaw = (BranchE & cond) | JumpE;
        jalrSum  = srcA + ImmExtE;
        target   = JalrE ? {jalrSum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);
    end

`ifdef EXEC_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fmA, fmB, fmProd;

    // Combinational multiplier; operands sign-extended per op, low 2*XLEN bits exact
    always_comb begin
        fmA        = {{XLEN{((funct3 == MD_MULH) || (funct3 == MD_MULHSU)) & srcA[XLEN-1]}}, srcA};
        fmB        = {{XLEN{(funct3 == MD_MULH) & srcB[XLEN-1]}}, srcB};
        fmProd     = fmA * fmB;
        fastMul    = MulDivE & ~funct3[2];
        fastResult = (funct3 == MD_MUL) ? fmProd[XLEN-1:0] : fmProd[2*XLEN-1:XLEN];
    end
`else
    assign fastMul    = 1'b0;
    assign fastResult = '0;
`endif

    assign mdStart = MulDivE & ~fastMul;

    muldiv_iter #(.XLEN(XLEN)) uMulDiv (
        .clk    (clk),
        .rst    (rst),
        .start  (mdStart),
        .op     (funct3),
        .a      (srcA),
        .b      (srcB),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
    );

    assign StallE      = mdBusy;
    assign PCSrcE      = pcSrcRaw & ~StallE;
    assign PCTargetE   = StallE ? '0 : (pcSrcRaw ? target : PCPlus4E);
    assign MispredictE = ~StallE & (BranchE | JumpE) & (pcSrcRaw != Predict_branchE);

    // Result that EX hands to MEM this cycle
    always_comb begin
        exResult = aluResult;
        if (mdDone)       exResult = mdResult;
        else if (fastMul) exResult = fastResult;
    end

    // EX/MEM register; a stalled EX inserts a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            InstrM     <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
        end else begin
            ALUResultM <= exResult;
            WriteDataM <= srcB;
            PCPlus4M   <= PCPlus4E;
            InstrM     <= InstrE;
            ResultSrcM <= ResultSrcE;
            RdM        <= StallE ? '0 : RdE;
            RegWriteM  <= RegWriteE & ~StallE;
            MemWriteM  <= MemWriteE & ~StallE;
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: directed forwarding, branch and
// mul/div cases plus randomized ALU, branch and mul/div traffic checked
// against an arithmetic reference model. Honours EXEC_FAST_MUL_EN.
module tb_execute_stage_md;
    localparam int XLEN = 32;
    localparam int RDW  = 5;

    logic            clk, rst;
    logic [XLEN-1:0] RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE, ResultW;
    logic [31:0]     InstrE;
    logic [RDW-1:0]  RdE;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, MulDivE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ResultSrcE, ForwardAE, ForwardBE;
    logic            Predict_branchE;
    logic            PCSrcE, MispredictE, StallE;
    logic [XLEN-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [31:0]     InstrM;
    logic [RDW-1:0]  RdM;
    logic            RegWriteM, MemWriteM;
    logic [1:0]      ResultSrcM;

    int nChecks = 0;
    int nFail   = 0;
    logic [31:0] expMem = '0;

    execute_stage_md #(.XLEN(XLEN), .RDW(RDW)) dut (
        .clk(clk), .rst(rst), .RD1_E(RD1_E), .RD2_E(RD2_E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .InstrE(InstrE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE),
        .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .ResultW(ResultW), .Predict_branchE(Predict_branchE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .MispredictE(MispredictE),
        .StallE(StallE), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .InstrM(InstrM), .RdM(RdM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        RD1_E = '0; RD2_E = '0; PCE = '0; PCPlus4E = '0; ImmExtE = '0; ResultW = '0;
        InstrE = '0; RdE = '0; RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
        JalrE = 0; ALUSrcE = 0; MulDivE = 0; ALUControlE = 3'd0; ResultSrcE = '0;
        ForwardAE = '0; ForwardBE = '0; Predict_branchE = 0;
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] refMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pu = ua / ub; return pu[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                pu = ua % ub; return pu[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b, input logic arith);
        logic signed [31:0] as_, bs_, r;
        as_ = a;
        bs_ = b;
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (as_ < bs_) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: begin
                if (arith) begin r = as_ >>> b[4:0]; return r; end
                return a >> b[4:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] rd, input logic [31:0] wb);
        case (sel)
            2'd0: return rd;
            2'd1: return wb;
            2'd2: return expMem;
            default: return 32'd0;
        endcase
    endfunction

    task automatic aluOp(input string tag, input logic [2:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [31:0] resW, input logic aluSrc, input logic [31:0] instr, input logic [4:0] rd);
        logic [31:0] a, b, exp, pc4;
        @(negedge clk);
        clearInputs();
        pc4 = $urandom;
        ALUControlE = ctl; ForwardAE = fa; ForwardBE = fb; RD1_E = rd1; RD2_E = rd2;
        ImmExtE = imm; ResultW = resW; ALUSrcE = aluSrc; InstrE = instr; RdE = rd;
        RegWriteE = 1'b1; PCPlus4E = pc4;
        a   = fwdVal(fa, rd1, resW);
        b   = fwdVal(fb, rd2, resW);
        exp = refAlu(ctl, a, aluSrc ? imm : b, instr[30]);
        #1;
        checkVal({tag, "_stall"}, StallE, 0);
        @(posedge clk);
        #1;
        checkVal({tag, "_res"}, ALUResultM, exp);
        checkVal({tag, "_wdata"}, WriteDataM, b);
        checkVal({tag, "_rd"}, RdM, rd);
        checkVal({tag, "_we"}, RegWriteM, 1);
        checkVal({tag, "_pc4"}, PCPlus4M, pc4);
        checkVal({tag, "_instr"}, InstrM, instr);
        expMem = exp;
    endtask

    task automatic mdOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic useFwd);
        logic [31:0] exp;
        logic [4:0]  rd;
        int          stallCnt, expStall;
        logic        bubbleBad;
        @(negedge clk);
        clearInputs();
        rd = 5'($urandom_range(1, 31));
        MulDivE = 1'b1; RegWriteE = 1'b1; RdE = rd;
        InstrE = 32'h0200_0033 | (32'(op) << 12);
        if (useFwd) begin ForwardAE = 2'd1; ResultW = a; RD1_E = $urandom; end
        else        RD1_E = a;
        RD2_E = b;
        exp = refMd(op, a, b);
        expStall = XLEN + 1;
`ifdef EXEC_FAST_MUL_EN
        if (op < 3'd4) expStall = 0;
`endif
        stallCnt  = 0;
        bubbleBad = 1'b0;
        #1;
        while (StallE && stallCnt < 100) begin
            stallCnt++;
            @(posedge clk);
            #1;
            if (RegWriteM !== 1'b0 || RdM !== '0) bubbleBad = 1'b1;
            @(negedge clk);
            RD1_E = $urandom; RD2_E = $urandom; ResultW = $urandom;
            ForwardAE = 2'($urandom_range(0, 2)); ForwardBE = 2'($urandom_range(0, 2));
            #1;
        end
        checkVal({tag, "_stallcycles"}, stallCnt, expStall);
        checkVal({tag, "_bubble"}, bubbleBad, 0);
        @(posedge clk);
        #1;
        checkVal({tag, "_res"}, ALUResultM, exp);
        checkVal({tag, "_we"}, RegWriteM, 1);
        checkVal({tag, "_rd"}, RdM, rd);
        expMem = exp;
        @(negedge clk);
        clearInputs();
    endtask

    task automatic branchCheck(input string tag, input logic src, input logic [31:0] tgt, input logic mis);
        checkVal({tag, "_pcsrc"}, PCSrcE, src);
        checkVal({tag, "_target"}, PCTargetE, tgt);
        checkVal({tag, "_mispredict"}, MispredictE, mis);
    endtask

    initial begin
        logic [31:0] a, b, pc, imm;
        logic        beq, pred, taken;
        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_alu", ALUResultM, 0);
        checkVal("rst_wdata", WriteDataM, 0);
        checkVal("rst_pc4", PCPlus4M, 0);
        checkVal("rst_instr", InstrM, 0);
        checkVal("rst_rd", RdM, 0);
        checkVal("rst_we", RegWriteM, 0);
        checkVal("rst_mwe", MemWriteM, 0);
        checkVal("rst_rsrc", ResultSrcM, 0);
        checkVal("rst_stall", StallE, 0);
        @(negedge clk);
        rst = 1'b0;

        // ADDI x1 = 10, then ADD x3 with SrcA forwarded from MEM
        aluOp("addi", 3'd0, 2'd0, 2'd0, 32'd10, 32'd0, 32'd0, 32'd0, 1'b1, 32'h0000_0013, 5'd1);
        aluOp("add_fwd", 3'd0, 2'd2, 2'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 32'h0000_0033, 5'd3);

        // BEQ taken, predicted not-taken then taken
        @(negedge clk);
        clearInputs();
        BranchE = 1; ALUControlE = 3'd1; RD1_E = 5; RD2_E = 5;
        PCE = 32'h100; ImmExtE = 32'h20; PCPlus4E = 32'h104; Predict_branchE = 0;
        #1;
        branchCheck("beq_np", 1, 32'h120, 1);
        Predict_branchE = 1;
        #1;
        branchCheck("beq_p", 1, 32'h120, 0);
        // BNE not taken, predicted taken
        InstrE = 32'h0000_1000;
        #1;
        branchCheck("bne", 0, 32'h104, 1);
        // JALR with low-bit clearing
        clearInputs();
        JumpE = 1; JalrE = 1; ALUSrcE = 1; RD1_E = 32'h201; ImmExtE = 32'h4;
        PCE = 32'h400; PCPlus4E = 32'h404; Predict_branchE = 1;
        #1;
        branchCheck("jalr", 1, 32'h204, 0);

        // Random BEQ/BNE
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clearInputs();
            a    = $urandom;
            b    = ($urandom_range(0, 1) == 1) ? a : 32'($urandom);
            beq  = 1'($urandom_range(0, 1));
            pred = 1'($urandom_range(0, 1));
            pc   = {$urandom, 2'b00};
            imm  = {$urandom_range(0, 4095), 1'b0};
            taken = beq ? (a == b) : (a != b);
            BranchE = 1; ALUControlE = 3'd1; RD1_E = a; RD2_E = b;
            InstrE = beq ? 32'h0 : 32'h0000_1000;
            PCE = pc; ImmExtE = imm; PCPlus4E = pc + 4; Predict_branchE = pred;
            #1;
            branchCheck("rnd_br", taken, taken ? pc + imm : pc + 4, taken != pred);
        end

        // Random ALU traffic with forwarding
        aluOp("seed", 3'd0, 2'd0, 2'd0, $urandom, $urandom, 32'd0, 32'd0, 1'b0, 32'h33, 5'd2);
        for (int i = 0; i < 20; i++) begin
            aluOp("rnd_alu", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                  $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom & 32'h4000_0000, 5'($urandom_range(1, 31)));
        end

        // Directed mul/div corner cases
        mdOp("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        mdOp("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        mdOp("divu_zero", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        mdOp("rem_zero", 3'd6, 32'hFFFF_FF00, 32'd0, 1'b0);
        mdOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        mdOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        mdOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        mdOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Random mul/div with scrambled forwarding inputs during RUN
        for (int i = 0; i < 24; i++) begin
            mdOp("rnd_md", 3'($urandom_range(0, 7)), pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a divide aborts it
        @(negedge clk);
        clearInputs();
        MulDivE = 1; RegWriteE = 1; RdE = 5'd9; InstrE = 32'h0200_4033;
        RD1_E = 32'hFFFF_FFF9; RD2_E = 32'd2;
        repeat (6) @(negedge clk);
        #1;
        checkVal("mid_run_stall", StallE, 1);
        rst = 1'b1;
        MulDivE = 0; RegWriteE = 0;
        #1;
        checkVal("rst_run_stall", StallE, 0);
        checkVal("rst_run_we", RegWriteM, 0);
        checkVal("rst_run_alu", ALUResultM, 0);
        @(negedge clk);
        rst = 1'b0;
        clearInputs();
        repeat (XLEN + 4) @(negedge clk);
        #1;
        checkVal("post_rst_stall", StallE, 0);
        checkVal("post_rst_we", RegWriteM, 0);
        mdOp("after_rst", 3'd4, 32'd100, 32'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
